ksa_mem_arbiter: RTL
====================

KSA_MEM_ARBITER -- requirements
Module: ksa_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, number of requesters (0=fill, 1=shuffle, 2=decrypt).
REQ-002 SHALL have one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock (CLOCK_50 domain).
REQ-003 SHALL have reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have req  input  NUM_REQ  per-requester bus request, held for the whole transaction.
REQ-005 SHALL have we  input  NUM_REQ  per-requester write enable.
REQ-006 SHALL have addr  input  NUM_REQ x 8  per-requester address.
REQ-007 SHALL have wdata  input  NUM_REQ x 8  per-requester write data.
REQ-008 SHALL have gnt  output  NUM_REQ  one-hot grant, registered.
REQ-009 SHALL have rvalid  output  NUM_REQ  per-requester read-data-valid pulse, registered.
REQ-010 SHALL have rdata  output  8  mem_q broadcast to all requesters.
REQ-011 SHALL have mem_addr, mem_data  output  8 each  to s_memory address/data.
REQ-012 SHALL have mem_wren  output  1  to s_memory wren.
REQ-013 SHALL have mem_q  input  8  s_memory q, valid one clock after the address is sampled.
REQ-014 SHALL have busy  output  1  high while any grant is held; owner  output  2  index of current owner.

Function
REQ-015 SHALL implement states IDLE and OWNED only.
REQ-016 IDLE: at most one grant per cycle; with any req high, pick a winner, assert its gnt and go to OWNED at the next edge.
REQ-017 OWNED: hold gnt while the owner's req stays high; all other requests are ignored (lock for read-modify-write swaps).
REQ-018 OWNED, owner req low: clear gnt at the next edge and return to IDLE; arbitration resumes in that IDLE cycle, so there is always at least one idle cycle between grants.
REQ-019 While gnt[i] is high and req[i] is high: mem_addr=addr[i], mem_data=wdata[i], mem_wren=we[i], all combinational.
REQ-020 Otherwise mem_wren=0, mem_addr=0, mem_data=0; we from any non-granted requester never reaches the RAM.
REQ-021 A read (gnt[i], req[i], we[i]=0) in cycle t SHALL pulse rvalid[i] in cycle t+1; rdata is valid in that cycle.
REQ-022 A read issued in the owner's last cycle SHALL still produce its rvalid after gnt drops.
REQ-023 Writes SHALL produce no rvalid.
REQ-024 Simultaneous requests SHALL be resolved by the priority rule in REQ-029.
REQ-025 Address wrap 255->0 is the requester's concern; the arbiter passes all 8 bits unchanged.

Reset
REQ-026 On reset_n low, asynchronously: state=IDLE, gnt=0, rvalid=0, busy=0, owner=0, round-robin pointer=0; mem_wren=0 immediately.
REQ-027 Reset asserted mid-transaction SHALL abort it; any pending rvalid is discarded.
REQ-028 After reset release, the first arbitration occurs at the first rising edge with reset_n high.

Configuration
REQ-029 With ARB_ROUND_ROBIN_EN defined, winner = first requesting index after the last owner (cyclic, pointer updated on grant); without it, fixed priority, lowest index wins.

Structure
REQ-030 Package ksa_pkg SHALL hold ADDR_W=8, DATA_W=8, NUM_REQ default, the arb_state_t enum (IDLE, OWNED) and the requester-id enum (REQ_FILL, REQ_SHUFFLE, REQ_DECRYPT).
REQ-031 Winner selection SHALL be the sub-module ksa_arb_pick (combinational: req, last-owner pointer -> one-hot winner).

Verification
REQ-032 Reset then req=3'b001, we=1, addr=0x05, wdata=0x05: gnt=001 the next cycle, mem_wren=1, mem_addr=0x05, RAM[5]=0x05.
REQ-033 req=3'b110 simultaneously: fixed build grants 1; RR build with pointer 0 grants 1, then after release and re-request grants 2.
REQ-034 Owner 1 reads 0x10 (RAM=0xAB) at cycle t: rvalid[1]=1 and rdata=0xAB at t+1; rvalid[0] and rvalid[2] stay 0.
REQ-035 Owner 1 holds while req[0] rises: gnt stays 010 for 20 cycles; mem_wren follows only we[1]; after release, gnt=001 two edges later.
REQ-036 reset_n low during OWNED: gnt=0 and mem_wren=0 immediately, no rvalid; resumes correctly after release.
REQ-037 Non-granted requester drives we=1, addr=0x20: RAM[0x20] unchanged.

Source files
------------

// File: rtl/ksa_pkg.sv
// rtl/ksa_pkg.sv - shared widths, arbiter state and requester ids for the KSA memory arbiter
package ksa_pkg;

    localparam int ADDR_W      = 8;
    localparam int DATA_W      = 8;
    localparam int NUM_REQ_DEF = 3;
    localparam int OWN_W       = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    typedef enum logic [OWN_W-1:0] {
        REQ_FILL    = 2'd0,
        REQ_SHUFFLE = 2'd1,
        REQ_DECRYPT = 2'd2
    } req_id_t;

endpackage

// File: rtl/ksa_arb_pick.sv
// rtl/ksa_arb_pick.sv - combinational winner pick; ARB_ROUND_ROBIN_EN selects round-robin, else fixed priority
module ksa_arb_pick
    import ksa_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [OWN_W-1:0]   last,
    output logic [NUM_REQ-1:0] win
);

    logic found;

`ifdef ARB_ROUND_ROBIN_EN
    // Scan starts just after the previous owner so it is tried last.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req[(int'(last) + k) % NUM_REQ]) begin
                win[(int'(last) + k) % NUM_REQ] = 1'b1;
                found = 1'b1;
            end
        end
    end
`else
    logic unused_last;
    assign unused_last = ^last;

    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[k]) begin
                win[k] = 1'b1;
                found  = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/ksa_mem_arbiter.sv
// rtl/ksa_mem_arbiter.sv - locking arbiter sharing one s_memory port among fill/shuffle/decrypt
// Build option: ARB_ROUND_ROBIN_EN (round-robin pick instead of fixed priority).
module ksa_mem_arbiter
    import ksa_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             we,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_REQ-1:0]             rvalid,
    output logic [DATA_W-1:0]              rdata,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [DATA_W-1:0]              mem_data,
    output logic                           mem_wren,
    input  logic [DATA_W-1:0]              mem_q,
    output logic                           busy,
    output logic [OWN_W-1:0]               owner
);

    arb_state_t         state, state_nxt;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic [NUM_REQ-1:0] win;
    logic [OWN_W-1:0]   win_idx;
    logic [OWN_W-1:0]   owner_nxt;

    // The owner register doubles as the round-robin pointer.
    ksa_arb_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req  (req),
        .last (owner),
        .win  (win)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win[i]) win_idx = OWN_W'(i);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            gnt    <= '0;
            rvalid <= '0;
            busy   <= 1'b0;
            owner  <= '0;
        end else begin
            state  <= state_nxt;
            gnt    <= gnt_nxt;
            rvalid <= gnt & req & ~we;
            busy   <= |gnt_nxt;
            owner  <= owner_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        owner_nxt = owner;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt = OWNED;
                    gnt_nxt   = win;
                    owner_nxt = win_idx;
                end
            end
            OWNED: begin
                if ((gnt & req) == '0) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    // Only the granted, still-requesting port may drive the RAM.
    always_comb begin
        mem_addr = '0;
        mem_data = '0;
        mem_wren = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i] && req[i]) begin
                mem_addr = addr[i];
                mem_data = wdata[i];
                mem_wren = we[i];
            end
        end
    end

    assign rdata = mem_q;

endmodule
